// File: rtl/uart_tx_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_engine_if
// Purpose  : Register-side bundle between the APB block and the TX engine.
// Revision : 1.0
// ============================================================================
interface uart_tx_engine_if #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
);
  localparam int c_lvl_w = $clog2(DEPTH) + 1;

  logic               wr_en;
  logic [7:0]         wr_data;
  logic               uart_en;
  logic               fifo_en;
  logic [DIV_W-1:0]   brd;
  logic [1:0]         wlen;
  logic               pen;
  logic               eps;
  logic               sps;
  logic               stp2;
  logic               brk;
  logic               UARTTXD;
  logic               txff;
  logic               txfe;
  logic               busy;
  logic [c_lvl_w-1:0] tx_level;

  modport master (
    output wr_en, wr_data, uart_en, fifo_en, brd, wlen, pen, eps, sps, stp2, brk,
    input  UARTTXD, txff, txfe, busy, tx_level
  );

  modport slave (
    input  wr_en, wr_data, uart_en, fifo_en, brd, wlen, pen, eps, sps, stp2, brk,
    output UARTTXD, txff, txfe, busy, tx_level
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_engine
// Purpose  : PL011-style transmit FIFO, baud16 divider and frame serializer.
// Revision : 1.0
// ============================================================================
module uart_tx_engine #(
  parameter int DEPTH = 16,
  parameter int DIV_W = 16
) (
  input  logic            UARTCLK,
  input  logic            UARTRST,
  uart_tx_engine_if.slave bus
);
  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_lvl_w = c_ptr_w + 1;
  localparam logic [c_lvl_w-1:0] c_cap_fifo = c_lvl_w'(DEPTH);
  localparam logic [c_lvl_w-1:0] c_cap_char = c_lvl_w'(1);

  localparam logic [2:0] c_idle   = 3'd0;
  localparam logic [2:0] c_start  = 3'd1;
  localparam logic [2:0] c_data   = 3'd2;
  localparam logic [2:0] c_parity = 3'd3;
  localparam logic [2:0] c_stop1  = 3'd4;
  localparam logic [2:0] c_stop2  = 3'd5;

  logic [7:0]         fifo_mem [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [c_lvl_w-1:0] level_q, level_d;
  logic               txff_q, txff_d, txfe_q, txfe_d, fifo_en_q;
  logic [2:0]         state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         sub_q, sub_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d, last_bit_q, last_bit_d;
  logic [7:0]         shift_q, shift_d;
  logic               pen_q, pen_d, stp2_q, stp2_d, par_q, par_d, txd_q, txd_d;
  logic               flush, start, push_ok, tick, bit_end, brd_zero;
  logic [7:0]         head_masked;

  // A change of fifo_en flushes the queue; pushes and pops are held off that cycle.
  always_comb begin
    brd_zero    = (bus.brd == '0);
    flush       = (bus.fifo_en != fifo_en_q);
    start       = (state_q == c_idle) && bus.uart_en && !txfe_q && !brd_zero && !flush;
    push_ok     = bus.wr_en && !flush && (!txff_q || start);
    head_masked = fifo_mem[rd_ptr_q] & (8'hFF >> (2'd3 - bus.wlen));
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
      if (start)   rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      level_d = level_q + c_lvl_w'(push_ok) - c_lvl_w'(start);
    end
    txfe_d = (level_d == '0);
    txff_d = (level_d == (bus.fifo_en ? c_cap_fifo : c_cap_char));
  end

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    sub_d      = sub_q;
    bit_cnt_d  = bit_cnt_q;
    last_bit_d = last_bit_q;
    shift_d    = shift_q;
    pen_d      = pen_q;
    stp2_d     = stp2_q;
    par_d      = par_q;
    txd_d      = txd_q;
    bit_end    = 1'b0;
    tick       = !brd_zero && (div_q >= (bus.brd - DIV_W'(1)));

    // 16 divider ticks make one bit period; a zero divisor freezes the frame.
    if (start) begin
      div_d = '0;
      sub_d = '0;
    end else if ((state_q != c_idle) && !brd_zero) begin
      if (tick) begin
        div_d   = '0;
        sub_d   = sub_q + 4'd1;
        bit_end = (sub_q == 4'hF);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (state_q)
      c_idle: begin
        if (start) begin
          state_d    = c_start;
          shift_d    = head_masked;
          last_bit_d = {1'b0, bus.wlen} + 3'd4;
          pen_d      = bus.pen;
          stp2_d     = bus.stp2;
          par_d      = bus.sps ? ~bus.eps : (bus.eps ? ^head_masked : ~^head_masked);
          txd_d      = 1'b0;
        end
      end
      c_start: begin
        if (bit_end) begin
          state_d   = c_data;
          bit_cnt_d = '0;
          txd_d     = shift_q[0];
        end
      end
      c_data: begin
        if (bit_end) begin
          if (bit_cnt_q == last_bit_q) begin
            state_d = pen_q ? c_parity : c_stop1;
            txd_d   = pen_q ? par_q : 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = shift_q >> 1;
            txd_d     = shift_q[1];
          end
        end
      end
      c_parity: begin
        if (bit_end) begin
          state_d = c_stop1;
          txd_d   = 1'b1;
        end
      end
      c_stop1: begin
        if (bit_end) begin
          state_d = stp2_q ? c_stop2 : c_idle;
          txd_d   = 1'b1;
        end
      end
      c_stop2: begin
        if (bit_end) begin
          state_d = c_idle;
          txd_d   = 1'b1;
        end
      end
      default: begin
        state_d = c_idle;
        txd_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge UARTCLK or posedge UARTRST) begin
    if (UARTRST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      txff_q     <= 1'b0;
      txfe_q     <= 1'b1;
      fifo_en_q  <= 1'b0;
      state_q    <= c_idle;
      div_q      <= '0;
      sub_q      <= '0;
      bit_cnt_q  <= '0;
      last_bit_q <= '0;
      shift_q    <= '0;
      pen_q      <= 1'b0;
      stp2_q     <= 1'b0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      txff_q     <= txff_d;
      txfe_q     <= txfe_d;
      fifo_en_q  <= bus.fifo_en;
      state_q    <= state_d;
      div_q      <= div_d;
      sub_q      <= sub_d;
      bit_cnt_q  <= bit_cnt_d;
      last_bit_q <= last_bit_d;
      shift_q    <= shift_d;
      pen_q      <= pen_d;
      stp2_q     <= stp2_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
    end
  end

  always_ff @(posedge UARTCLK) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.UARTTXD  = txd_q & ~bus.brk;
  assign bus.txff     = txff_q;
  assign bus.txfe     = txfe_q;
  assign bus.busy     = ~txfe_q | (state_q != c_idle);
  assign bus.tx_level = level_q;
endmodule
`default_nettype wire

// File: doc/uart_tx_engine.md
# uart_tx_engine

Transmit datapath of the PL011-compatible UART: a 16-entry transmit FIFO, a 16x baud-tick divider and a frame serializer driving UARTTXD. It sits directly downstream of the APB register interface. That interface pushes UARTDR writes into it and supplies the line-control (LCR_H), control (CR) and baud-divisor fields. The FIFO status it returns feeds the flag register and the TX interrupt/DMA logic.

## Interface
Parameters:
- DEPTH, 16, transmit FIFO entries (power of two)
- DIV_W, 16, baud divisor width

Ports:
- UARTCLK  in  1  sole clock; all logic on its rising edge
- UARTRST  in  1  asynchronous, active-high reset
- wr_en  in  1  push wr_data into FIFO (one-cycle strobe)
- wr_data  in  8  character to transmit
- uart_en  in  1  UARTEN & TXE; start of new frames permitted
- fifo_en  in  1  LCR_H.FEN; 0 = one-entry character mode
- brd  in  DIV_W  UARTCLK cycles per baud16 tick; 0 = divider halted
- wlen  in  2  word length: 00=5, 01=6, 10=7, 11=8 bits
- pen, eps, sps, stp2, brk  in  1 each  parity enable, even parity, stick parity, two stop bits, send break
- UARTTXD  out  1  serial output, idle high
- txff  out  1  FIFO full
- txfe  out  1  FIFO empty
- busy  out  1  FIFO non-empty or frame in progress
- tx_level  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- FIFO capacity is DEPTH when fifo_en=1 and 1 when fifo_en=0; txff = (tx_level == capacity); txfe = (tx_level == 0).
- Push while full is dropped silently; tx_level is unchanged and there is no error flag.
- Simultaneous push and pop while full: push accepted, tx_level unchanged.
- Any change of fifo_en flushes the FIFO (tx_level becomes 0); a frame already in the shifter completes.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE -> START when uart_en=1, txfe=0 and brd!=0. The FIFO head is popped into the shift register on that same edge.
- START -> DATA after 1 bit period.
- DATA shifts wlen+5 bits LSB first, one bit per bit period, then goes to PARITY if pen=1, else STOP1.
- PARITY -> STOP1 after 1 bit period.
- STOP1 -> STOP2 if stp2=1, else IDLE. STOP2 -> IDLE.
- A back-to-back frame starts from IDLE on the cycle after STOP completes; there is no extra idle bit.
- Parity bit:
  - sps=1: bit = ~eps.
  - sps=0, eps=1: bit = XOR of the transmitted data bits.
  - sps=0, eps=0: bit = ~XOR of the transmitted data bits.
- Bits above the word length in wr_data are ignored.
- Line values: UARTTXD = 0 in START, data/parity bit in DATA/PARITY, 1 in STOP/IDLE.
- brk=1 forces UARTTXD=0 combinationally over the registered value; the FSM keeps running.
- uart_en falling mid-frame: the current frame completes, then the FSM stays in IDLE with the FIFO contents retained.
- LCR_H fields are sampled on each IDLE->START transition and held for the whole frame.

## Timing
- Reset values: UARTTXD=1, txff=0, txfe=1, busy=0, tx_level=0, FSM=IDLE, divider=0.
- Reset asserted mid-frame returns all of the above immediately (asynchronously).
- Divider: counts 0..brd-1 and emits a tick when it reaches brd-1. It is cleared on the IDLE->START edge, so every bit period is exactly 16*brd UARTCLK cycles.
- If brd becomes 0 mid-frame, the FSM freezes in its current state and UARTTXD holds.
- Start-up latency: push at edge N with FSM IDLE → tx_level=1 after N; pop and START entry at N+1; UARTTXD registered low after N+1.
- Frame length = (1 + wlen+5 + pen + 1 + stp2) * 16 * brd cycles.
- tx_level, txff and txfe are registered and update on the edge of the push/pop.
- busy = ~txfe | (FSM != IDLE).

## Test plan
- Reset state: assert UARTRST with no clock → UARTTXD=1, txfe=1, busy=0, tx_level=0.
- Basic frame: brd=4, wlen=11, pen=0, stp2=0, push 0x55 → line reads low, 1,0,1,0,1,0,1,0, high; each bit 64 cycles; frame 640 cycles; busy drops on the next cycle.
- Parity and stop bits:
  - wlen=00, pen=1, eps=1, stp2=1, push 0x1F → 5 ones, then parity 1, two stop bits; frame = 9 bits * 16 * brd.
  - sps=1, eps=1 → parity bit is 0 regardless of data.
- FIFO limits:
  - fifo_en=1, uart_en=0, push 17 bytes → tx_level=16, txff=1, 17th byte dropped.
  - Enable uart_en → 16 back-to-back frames in push order, with no gaps between frames.
- Character mode: fifo_en=0, uart_en=0, push 0xA1 then 0xB2 → txff=1, tx_level=1; 0xB2 dropped; only 0xA1 is transmitted.
- Break and disable: assert brk mid-frame → UARTTXD=0 while brk=1, FSM timing unaffected. Drop uart_en mid-frame with 2 entries queued → current frame completes, tx_level stays 2, UARTTXD=1.
